adain_seq: RTL and testbench

ADAIN_SEQ -- requirements
Module: adain_seq

---
 rtl/adain_seq_if.sv | 53 +++++
 rtl/adain_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_adain_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adain_seq_if.sv
// rtl/adain_seq_if.sv - handshake/bus bundle between the AdaIN frame sequencer and its environment
//
// Purpose: groups the frame request, configuration, control-unit command/status
// and feature-memory read signals of adain_seq into one interface.
//
// Signal summary:
//   go          1        single-cycle frame request
//   cfg_N       N_W      feature-map side, latched on accepted go
//   cfg_C       C_W      channel count, latched on accepted go
//   start       2        command to control unit: 01 stats, 10 normalize, 00 none
//   N           N_W      latched side, stable for the whole frame
//   done        2        control-unit status: 01 stats finished, 10 normalize finished
//   rd_en       1        feature-memory read strobe
//   rd_addr     ADDR_W   feature-memory word address
//   ch_idx      CI_W     current channel index
//   busy        1        frame in progress
//   frame_done  1        one-cycle end-of-frame pulse
//   err         1        watchdog error pulse
//
// Modports: slave = sequencer side, master = environment side.

interface adain_seq_if #(
  parameter int N_MAX  = 128,
  parameter int C_MAX  = 512,
  parameter int ADDR_W = 23
);
  localparam int N_W  = $clog2(N_MAX + 1);
  localparam int C_W  = $clog2(C_MAX + 1);
  localparam int CI_W = $clog2(C_MAX);

  logic              go;
  logic [N_W-1:0]    cfg_N;
  logic [C_W-1:0]    cfg_C;
  logic [1:0]        start;
  logic [N_W-1:0]    N;
  logic [1:0]        done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CI_W-1:0]   ch_idx;
  logic              busy;
  logic              frame_done;
  logic              err;

  modport slave (
    input  go, cfg_N, cfg_C, done,
    output start, N, rd_en, rd_addr, ch_idx, busy, frame_done, err
  );

  modport master (
    output go, cfg_N, cfg_C, done,
    input  start, N, rd_en, rd_addr, ch_idx, busy, frame_done, err
  );
endinterface

// File: rtl/adain_seq.sv
// rtl/adain_seq.sv - AdaIN frame sequencer: per-channel statistics and normalize passes
//
// Purpose: for each of C channels, commands a statistics pass (start=01) while
// streaming N*N feature words back-to-back, waits for done=01, then commands a
// normalize pass (start=10) streaming the same N*N words one every 4th cycle,
// waits for done=10 and moves to the next channel. Ends with a frame_done pulse.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   adain_seq_if.slave (go/cfg_N/cfg_C/done in; start/N/rd_en/rd_addr/
//         ch_idx/busy/frame_done/err out)
//
// Optional feature: define ADAIN_SEQ_TIMEOUT_EN to add a watchdog on the two
// wait states; after TIMEOUT cycles it pulses err and returns to IDLE without
// frame_done. Without the macro err is tied low and the waits block forever.

module adain_seq #(
  parameter int N_MAX   = 128,
  parameter int C_MAX   = 512,
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  adain_seq_if.slave  bus
);
  localparam int N_W  = $clog2(N_MAX + 1);
  localparam int C_W  = $clog2(C_MAX + 1);
  localparam int CI_W = $clog2(C_MAX);

  typedef enum logic [2:0] {
    IDLE, S_START, S_STREAM, S_WAIT, N_START, N_STREAM, N_WAIT, FIN
  } state_t;

  state_t            r_state;
  logic [N_W-1:0]    r_n;
  logic [C_W-1:0]    r_c;
  logic [CI_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [N_W-1:0]    r_row;
  logic [N_W-1:0]    r_col;
  logic [1:0]        r_ph;
  logic [1:0]        r_start;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_fdone;

`ifdef ADAIN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]   r_wdog;
  logic              r_err;
`endif

  // Row/column counters only decide when a pass ends; the address itself is a
  // running +1 because raster order over a full N x N tile is contiguous.
  logic w_col_last;
  logic w_row_last;
  logic w_pix_last;
  logic w_ch_last;

  assign w_col_last = ((r_col + N_W'(1)) == r_n);
  assign w_row_last = ((r_row + N_W'(1)) == r_n);
  assign w_pix_last = w_col_last && w_row_last;
  assign w_ch_last  = ((C_W'(r_ch) + C_W'(1)) == r_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_c     <= '0;
      r_ch    <= '0;
      r_base  <= '0;
      r_addr  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_ph    <= '0;
      r_start <= 2'b00;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
`ifdef ADAIN_SEQ_TIMEOUT_EN
      r_wdog  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      // Pulse-type outputs default low; states that need them re-assert.
      r_start <= 2'b00;
      r_rd_en <= 1'b0;
      r_fdone <= 1'b0;
`ifdef ADAIN_SEQ_TIMEOUT_EN
      r_err   <= 1'b0;
      r_wdog  <= '0;   // only the wait states keep it counting
`endif
      case (r_state)
        IDLE: begin
          if (bus.go) begin
            r_n    <= bus.cfg_N;
            r_c    <= bus.cfg_C;
            r_ch   <= '0;
            r_base <= '0;
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_busy <= 1'b1;
            if ((bus.cfg_N == '0) || (bus.cfg_C == '0)) begin
              r_state <= FIN;
            end else begin
              r_state <= S_START;
              r_start <= 2'b01;
            end
          end
        end

        S_START: begin
          r_state <= S_STREAM;
          r_rd_en <= 1'b1;
          r_addr  <= r_base;
          r_row   <= '0;
          r_col   <= '0;
        end

        S_STREAM: begin
          if (w_pix_last) begin
            r_state <= S_WAIT;
          end else begin
            r_rd_en <= 1'b1;
            r_addr  <= r_addr + ADDR_W'(1);
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + N_W'(1);
            end else begin
              r_col <= r_col + N_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (bus.done == 2'b01) begin
            r_state <= N_START;
            r_start <= 2'b10;
          end else begin
`ifdef ADAIN_SEQ_TIMEOUT_EN
            if (r_wdog == WD_W'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_wdog <= r_wdog + WD_W'(1);
            end
`endif
          end
        end

        N_START: begin
          r_state <= N_STREAM;
          r_rd_en <= 1'b1;
          r_addr  <= r_base;
          r_row   <= '0;
          r_col   <= '0;
          r_ph    <= '0;
        end

        // r_ph==0 marks the cycle whose read is on the bus; the next read
        // is issued when r_ph wraps from 3, giving one read every 4 cycles.
        N_STREAM: begin
          if ((r_ph == 2'd0) && w_pix_last) begin
            r_state <= N_WAIT;
          end else begin
            r_ph <= r_ph + 2'd1;
            if (r_ph == 2'd3) begin
              r_rd_en <= 1'b1;
              r_addr  <= r_addr + ADDR_W'(1);
            end
            if (r_ph == 2'd0) begin
              if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + N_W'(1);
              end else begin
                r_col <= r_col + N_W'(1);
              end
            end
          end
        end

        N_WAIT: begin
          if (bus.done == 2'b10) begin
            if (w_ch_last) begin
              r_state <= FIN;
            end else begin
              r_ch    <= r_ch + CI_W'(1);
              // r_addr holds the last word of this channel, so the next
              // channel starts right after it.
              r_base  <= r_addr + ADDR_W'(1);
              r_state <= S_START;
              r_start <= 2'b01;
            end
          end else begin
`ifdef ADAIN_SEQ_TIMEOUT_EN
            if (r_wdog == WD_W'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_wdog <= r_wdog + WD_W'(1);
            end
`endif
          end
        end

        FIN: begin
          r_fdone <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start      = r_start;
  assign bus.N          = r_n;
  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_addr;
  assign bus.ch_idx     = r_ch;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_fdone;
`ifdef ADAIN_SEQ_TIMEOUT_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_adain_seq.sv
// tb/tb_adain_seq.sv - directed self-checking bench for adain_seq

module tb_adain_seq;
  localparam int N_MAX  = 128;
  localparam int C_MAX  = 512;
  localparam int ADDR_W = 23;
`ifdef ADAIN_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65536;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_starts;
  int   n_fdones;

  adain_seq_if #(.N_MAX(N_MAX), .C_MAX(C_MAX), .ADDR_W(ADDR_W)) bus ();

  adain_seq #(
    .N_MAX(N_MAX), .C_MAX(C_MAX), .ADDR_W(ADDR_W), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start and frame_done are single-cycle registered pulses; count them
  // between edges.
  always @(negedge clk) begin
    if (bus.start != 2'b00) n_starts++;
    if (bus.frame_done) n_fdones++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame and checks every cycle of it against the expected
  // schedule. noise adds ignored go/done pulses and cfg changes mid-frame.
  task automatic run_frame(input int n, input int c, input bit noise);
    int base;
    int s0;
    int f0;
    s0 = n_starts;
    f0 = n_fdones;
    bus.cfg_N = n[7:0];
    bus.cfg_C = c[9:0];
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    if (noise) begin
      bus.cfg_N = 8'd3;
      bus.cfg_C = 10'd7;
    end
    chk("busy_on", bus.busy, 1);
    chk("N_latched", bus.N, n);
    for (int ch = 0; ch < c; ch++) begin
      base = ch * n * n;
      chk("s_start", bus.start, 2'b01);
      chk("ch_idx", bus.ch_idx, ch);
      chk("s_start_rd", bus.rd_en, 0);
      step();
      for (int p = 0; p < n * n; p++) begin
        chk("s_rd_en", bus.rd_en, 1);
        chk("s_addr", bus.rd_addr, base + p);
        chk("s_no_start", bus.start, 0);
        if (noise && p == 0) bus.go = 1'b1;
        step();
        bus.go = 1'b0;
      end
      bus.done = noise ? 2'b10 : 2'b00;
      for (int k = 0; k < 3; k++) begin
        chk("sw_rd_en", bus.rd_en, 0);
        chk("sw_start", bus.start, 0);
        step();
      end
      bus.done = 2'b01;
      step();
      bus.done = 2'b00;
      chk("n_start", bus.start, 2'b10);
      chk("n_start_rd", bus.rd_en, 0);
      step();
      for (int p = 0; p < n * n; p++) begin
        chk("n_rd_en", bus.rd_en, 1);
        chk("n_addr", bus.rd_addr, base + p);
        step();
        if (p < n * n - 1) begin
          for (int k = 0; k < 3; k++) begin
            chk("n_gap", bus.rd_en, 0);
            step();
          end
        end
      end
      bus.done = noise ? 2'b01 : 2'b00;
      for (int k = 0; k < 2; k++) begin
        chk("nw_rd_en", bus.rd_en, 0);
        chk("nw_start", bus.start, 0);
        step();
      end
      bus.done = 2'b10;
      step();
      bus.done = 2'b00;
    end
    chk("fin_busy", bus.busy, 1);
    chk("fin_fd_early", bus.frame_done, 0);
    chk("N_hold", bus.N, n);
    step();
    chk("frame_done", bus.frame_done, 1);
    chk("busy_off", bus.busy, 0);
    chk("fin_start", bus.start, 0);
    step();
    chk("fd_one_cycle", bus.frame_done, 0);
    chk("err_quiet", bus.err, 0);
    chk("start_pulses", n_starts - s0, 2 * c);
    chk("fd_pulses", n_fdones - f0, 1);
  endtask

  task automatic zero_frame(input int n, input int c);
    bus.cfg_N = n[7:0];
    bus.cfg_C = c[9:0];
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("z_busy", bus.busy, 1);
    chk("z_start", bus.start, 0);
    chk("z_rd_en", bus.rd_en, 0);
    chk("z_fd_early", bus.frame_done, 0);
    step();
    chk("z_frame_done", bus.frame_done, 1);
    chk("z_busy_off", bus.busy, 0);
    chk("z_rd_en2", bus.rd_en, 0);
    chk("z_start2", bus.start, 0);
    step();
    chk("z_fd_off", bus.frame_done, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_starts = 0;
    n_fdones = 0;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.cfg_N = '0;
    bus.cfg_C = '0;
    bus.done = 2'b00;
    step();
    step();
    chk("rst_start", bus.start, 0);
    chk("rst_N", bus.N, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_ch_idx", bus.ch_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    step();

    // Basic single-channel frame, multi-channel, N=1 (last addr C*N*N-1 = 1).
    run_frame(4, 1, 1'b0);
    run_frame(2, 3, 1'b0);
    run_frame(1, 2, 1'b0);
    // Same as the first frame with ignored go/done/cfg activity.
    run_frame(4, 1, 1'b1);

    // Degenerate configurations finish without any command or read.
    zero_frame(0, 5);
    zero_frame(3, 0);

    // Reset on the third statistics read, then an immediate new go.
    bus.cfg_N = 8'd4;
    bus.cfg_C = 10'd1;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    step();
    step();
    step();
    chk("abort_rd_en_pre", bus.rd_en, 1);
    chk("abort_addr_pre", bus.rd_addr, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_start", bus.start, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_addr", bus.rd_addr, 0);
    run_frame(4, 1, 1'b0);

`ifdef ADAIN_SEQ_TIMEOUT_EN
    // Watchdog: done stays 00 in S_WAIT.
    bus.cfg_N = 8'd1;
    bus.cfg_C = 10'd1;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    step();
    chk("to_read", bus.rd_en, 1);
    step();
    chk("to_wait", bus.rd_en, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 16) begin
        chk("to_err_early", bus.err, 0);
      end else begin
        chk("to_err", bus.err, 1);
        chk("to_busy", bus.busy, 0);
        chk("to_no_fd", bus.frame_done, 0);
      end
    end
    step();
    chk("to_err_pulse", bus.err, 0);
    chk("to_no_fd2", bus.frame_done, 0);
    chk("to_start_idle", bus.start, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
